// File: rtl/matrix_pkg.sv
// Shared constants for the 5x5 signed-8-bit matrix stages: sizes, packing helper, loader FSM encoding.
// Pure definitions; no latency or backpressure of its own.
package matrix_pkg;

    localparam int MAT_DIM   = 5;
    localparam int ELEM_W    = 8;
    localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;
    localparam int MAT_W     = MAT_ELEMS * ELEM_W;
    localparam int IDX_W     = 5;

    typedef logic [1:0] ld_state_t;

    localparam ld_state_t ST_LOAD_A = 2'd0;
    localparam ld_state_t ST_LOAD_B = 2'd1;
    localparam ld_state_t ST_FULL   = 2'd2;

    // Row-major slot number of element (i,j); bit offset is this times ELEM_W.
    function automatic logic [IDX_W-1:0] pack_idx(input int i, input int j);
        return IDX_W'(i * MAT_DIM + j);
    endfunction

endpackage

// File: rtl/matrix_byte_bank.sv
// 25x8 register bank with indexed write, synchronous clear and packed 200-bit read-out.
// Write visible after the writing edge; always accepts, no backpressure.
module matrix_byte_bank
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [ELEM_W-1:0] wdat_i,
    output logic [MAT_W-1:0]  rdat_o
);

    logic [ELEM_W-1:0] mem_q [MAT_ELEMS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAT_ELEMS; k++) begin
                mem_q[k] <= '0;
            end
        end else if (clr_i) begin
            for (int k = 0; k < MAT_ELEMS; k++) begin
                mem_q[k] <= '0;
            end
        end else if (we_i && (widx_i < IDX_W'(MAT_ELEMS))) begin
            mem_q[widx_i] <= wdat_i;
        end
    end

    for (genvar g = 0; g < MAT_ELEMS; g++) begin : g_pack
        assign rdat_o[g*ELEM_W +: ELEM_W] = mem_q[g];
    end

endmodule

// File: rtl/matrix_loader.sv
// Collects 25 A bytes then 25 B bytes into packed operand buses and holds them until acked.
// Byte visible one edge after accept; in_ready drops while FULL or during clear.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic [MAT_W-1:0]  matrix_A,
    output logic [MAT_W-1:0]  matrix_B,
    output logic              mat_valid,
    input  logic              mat_ack,
    output logic [IDX_W-1:0]  elem_idx,
    output logic              loading_b
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_ELEMS - 1);

    ld_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             accept;
    logic             last_slot;

    assign in_ready  = ((state_q == ST_LOAD_A) || (state_q == ST_LOAD_B)) && !clear;
    assign accept    = in_valid && in_ready;
    assign last_slot = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (clear) begin
            state_d = ST_LOAD_A;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD_A: begin
                    if (accept) begin
                        if (last_slot) begin
                            state_d = ST_LOAD_B;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (accept) begin
                        if (last_slot) begin
                            state_d = ST_FULL;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (mat_ack) begin
                        state_d = ST_LOAD_A;
                    end
                end
                default: begin
                    state_d = ST_LOAD_A;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD_A;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Accept is already masked by clear, so the banks see clear alone on a flush cycle.
    matrix_byte_bank u_bank_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clear),
        .we_i   (accept && (state_q == ST_LOAD_A)),
        .widx_i (idx_q),
        .wdat_i (in_data),
        .rdat_o (matrix_A)
    );

    matrix_byte_bank u_bank_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clear),
        .we_i   (accept && (state_q == ST_LOAD_B)),
        .widx_i (idx_q),
        .wdat_i (in_data),
        .rdat_o (matrix_B)
    );

    assign mat_valid = (state_q == ST_FULL);
    assign loading_b = (state_q == ST_LOAD_B);
    assign elem_idx  = idx_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed and random byte streams against a byte-count reference model of the loader.
module tb_matrix_loader;
    import matrix_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [ELEM_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              clear;
    logic [MAT_W-1:0]  matrix_A;
    logic [MAT_W-1:0]  matrix_B;
    logic              mat_valid;
    logic              mat_ack;
    logic [IDX_W-1:0]  elem_idx;
    logic              loading_b;

    matrix_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clear     (clear),
        .matrix_A  (matrix_A),
        .matrix_B  (matrix_B),
        .mat_valid (mat_valid),
        .mat_ack   (mat_ack),
        .elem_idx  (elem_idx),
        .loading_b (loading_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Model: n counts bytes accepted in the current load (0..50); 50 means operands held.
    logic [7:0] ma [25];
    logic [7:0] mb [25];
    int         n;

    task automatic chk(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MAT_W-1:0] pack(input logic [7:0] a [25]);
        logic [MAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAT_DIM; i++) begin
            for (int j = 0; j < MAT_DIM; j++) begin
                r[int'(pack_idx(i, j))*8 +: 8] = a[i*MAT_DIM + j];
            end
        end
        return r;
    endfunction

    task automatic model_zero();
        for (int k = 0; k < 25; k++) begin
            ma[k] = 8'h00;
            mb[k] = 8'h00;
        end
        n = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".matrix_A"},  matrix_A, pack(ma));
        chk({tag, ".matrix_B"},  matrix_B, pack(mb));
        chk({tag, ".mat_valid"}, MAT_W'(mat_valid), MAT_W'(n == 50));
        chk({tag, ".elem_idx"},  MAT_W'(elem_idx),  MAT_W'((n == 50) ? 0 : n % 25));
        chk({tag, ".loading_b"}, MAT_W'(loading_b), MAT_W'((n >= 25) && (n < 50)));
    endtask

    // Entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [7:0] d, input logic clr, input logic ack, input string tag);
        logic exp_rdy;
        in_valid = v;
        in_data  = d;
        clear    = clr;
        mat_ack  = ack;
        #1;
        exp_rdy = (n < 50) && !clr;
        chk({tag, ".in_ready"}, MAT_W'(in_ready), MAT_W'(exp_rdy));
        @(posedge clk);
        #1;
        if (clr) begin
            model_zero();
        end else if (v && exp_rdy) begin
            if (n < 25) ma[n] = d;
            else        mb[n-25] = d;
            n++;
        end else if (n == 50 && ack) begin
            n = 0;
        end
        check_outputs(tag);
    endtask

    // Drops rst_n between edges and checks the outputs before any edge arrives.
    task automatic async_reset(input string tag);
        in_valid = 1'b0;
        clear    = 1'b0;
        mat_ack  = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_zero();
        check_outputs(tag);
        chk({tag, ".in_ready"}, MAT_W'(in_ready), MAT_W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs({tag, "_rel"});
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clear    = 1'b0;
        mat_ack  = 1'b0;
        model_zero();
        #8;
        check_outputs("por");
        chk("por.in_ready", MAT_W'(in_ready), MAT_W'(1));
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back load: A = 10..250, B = 1..25.
        for (int k = 0; k < 50; k++) begin
            cycle(1'b1, (k < 25) ? 8'(10 * (k + 1)) : 8'(k - 24), 1'b0, 1'b0, "b2b");
        end
        chk("b2b.A_lo", MAT_W'(matrix_A[7:0]),     MAT_W'(8'd10));
        chk("b2b.A_hi", MAT_W'(matrix_A[199:192]), MAT_W'(8'd250));
        chk("b2b.B_hi", MAT_W'(matrix_B[199:192]), MAT_W'(8'd25));
        chk("b2b.valid", MAT_W'(mat_valid), MAT_W'(1));

        // Hold in FULL with a pending byte, then ack and load one byte.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 8'h7F, 1'b0, 1'b0, "hold");
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "ack");
        chk("ack.valid", MAT_W'(mat_valid), MAT_W'(0));
        cycle(1'b1, 8'h80, 1'b0, 1'b0, "post_ack");
        chk("post_ack.A_lo", MAT_W'(matrix_A[7:0]), MAT_W'(8'h80));

        // Fill up to B slot 12, then clear with a byte offered.
        while (n < 37) begin
            cycle(1'b1, 8'($urandom), 1'b0, 1'b0, "pre_clr");
        end
        chk("pre_clr.idx", MAT_W'(elem_idx), MAT_W'(12));
        cycle(1'b1, 8'h55, 1'b1, 1'b0, "clr");
        chk("clr.A_zero", matrix_A, '0);

        // Async reset in the middle of loading A.
        for (int k = 0; k < 7; k++) begin
            cycle(1'b1, 8'(k + 100), 1'b0, 1'b0, "mid");
        end
        async_reset("rst_mid");

        // Gapped stream: A = -5..-125, B = -1..-25, valid every other cycle.
        for (int k = 0; k < 50; k++) begin
            cycle(1'b0, 8'hEE, 1'b0, 1'b0, "gap_idle");
            cycle(1'b1, (k < 25) ? 8'(-5 * (k + 1)) : 8'(-(k - 24)), 1'b0, 1'b0, "gap");
        end
        chk("gap.A_hi", MAT_W'(matrix_A[199:192]), MAT_W'(8'h83));

        // Async reset while FULL, then reload all 127s / all -128s.
        async_reset("rst_full");
        for (int k = 0; k < 50; k++) begin
            cycle(1'b1, (k < 25) ? 8'h7F : 8'h80, 1'b0, 1'b0, "reload");
        end
        chk("reload.A", matrix_A, {25{8'h7F}});
        chk("reload.B", matrix_B, {25{8'h80}});
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "reload_ack");

        // Random traffic, including acks outside FULL and sparse clears.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) == 0), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
